// File: rtl/evict_wr_arb_pkg.sv
// Shared definitions for the eviction write arbiter: width defaults, FSM states,
// and the position of the requester tag bit inside an AXI ID.
// Latency: n/a (definitions only).   Backpressure: n/a.
package evict_wr_arb_pkg;

  localparam int ADDR_W_DEF    = 64;
  localparam int DATA_W_DEF    = 512;
  localparam int ID_W_DEF      = 16;
  localparam int MAX_OUTST_DEF = 8;
  localparam int TID_W         = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  // The top ID bit carries the requester index on the downstream port.
  function automatic int tag_bit(input int id_w);
    return id_w - 1;
  endfunction

endpackage

// File: rtl/evict_wr_arb_rr_arb2.sv
// Two-way round-robin picker; holds the last-granted index.
// Latency: pick is combinational; rr_last updates on the clock when take=1.
// Backpressure: none; the caller decides when a pick is consumed (take).
// Ports: req[1:0] requests, take = consume pick, any = some request, pick = winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any,
  output logic       pick
);

  logic rr_last;

  assign any = |req;
  // Contention goes to whoever did not win last; otherwise the lone requester.
  assign pick = (req == 2'b11) ? ~rr_last : req[1];

  // Reset to 1 so requester 0 wins the first contended round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (take) begin
      rr_last <= pick;
    end
  end

endmodule

// File: rtl/evict_wr_arb.sv
// Shares one single-beat AXI write port between eviction (req 0) and a second writer (req 1).
// Latency: eligible in cycle N -> downstream AW/W valid in N+1; one idle cycle between grants.
// Backpressure: AW/W readies pass through to the granted requester only; per-requester outstanding cap.
// Ports: s_aw*/s_w* per-requester request slices, s_b* routed responses, m_* downstream AXI, err_o sticky error.
module evict_wr_arb
  import evict_wr_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*ID_W-1:0]   s_awid_i,
  input  logic [2*ADDR_W-1:0] s_awaddr_i,
  input  logic [1:0]          s_awvalid_i,
  output logic [1:0]          s_awready_o,
  input  logic [2*DATA_W-1:0] s_wdata_i,
  input  logic [1:0]          s_wvalid_i,
  output logic [1:0]          s_wready_o,
  output logic [ID_W-1:0]     s_bid_o,
  output logic [1:0]          s_bvalid_o,
  input  logic [1:0]          s_bready_i,
  output logic [ID_W-1:0]     m_awid_o,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [ID_W-1:0]     m_wid_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  input  logic [ID_W-1:0]     m_bid_i,
  input  logic                m_bvalid_i,
  output logic                m_bready_o,
  output logic                err_o
);

  localparam int TB    = tag_bit(ID_W);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [ID_W-1:0]   awid_a   [2];
  logic [ADDR_W-1:0] awaddr_a [2];
  logic [DATA_W-1:0] wdata_a  [2];

  for (genvar g = 0; g < 2; g++) begin : g_split
    assign awid_a[g]   = s_awid_i[g*ID_W +: ID_W];
    assign awaddr_a[g] = s_awaddr_i[g*ADDR_W +: ADDR_W];
    assign wdata_a[g]  = s_wdata_i[g*DATA_W +: DATA_W];
  end

  state_t           state_q;
  logic             grant_q;
  logic             aw_done_q;
  logic             w_done_q;
  logic             err_q;
  logic [CNT_W-1:0] outst_q [2];

  logic [1:0]      elig;
  logic            any_elig;
  logic            pick;
  logic            xfer;
  logic [ID_W-1:0] sel_awid;
  logic            aw_hs;
  logic            w_hs;
  logic            b_tag;
  logic            b_hs;
  logic [1:0]      inc;
  logic [1:0]      dec;

  // A requester needs both AW and W ready to go, plus headroom in its counter.
  always_comb begin
    elig = '0;
    for (int r = 0; r < 2; r++) begin
      elig[r] = s_awvalid_i[r] & s_wvalid_i[r] & (outst_q[r] < MAX_CNT);
    end
  end

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .take  ((state_q == S_IDLE) & any_elig),
    .any   (any_elig),
    .pick  (pick)
  );

  assign xfer     = (state_q == S_XFER);
  assign sel_awid = awid_a[grant_q];

  // Forward path: only the granted requester sees readies; outputs idle at 0.
  always_comb begin
    s_awready_o = '0;
    s_wready_o  = '0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_awaddr_o  = '0;
    m_wdata_o   = '0;
    m_awid_o    = '0;
    if (xfer) begin
      m_awvalid_o          = s_awvalid_i[grant_q] & ~aw_done_q;
      m_wvalid_o           = s_wvalid_i[grant_q] & ~w_done_q;
      s_awready_o[grant_q] = m_awready_i & ~aw_done_q;
      s_wready_o[grant_q]  = m_wready_i & ~w_done_q;
      m_awaddr_o           = awaddr_a[grant_q];
      m_wdata_o            = wdata_a[grant_q];
      m_awid_o             = {grant_q, sel_awid[TB-1:0]};
    end
  end

  assign m_wid_o = m_awid_o;
  assign aw_hs   = m_awvalid_o & m_awready_i;
  assign w_hs    = m_wvalid_o & m_wready_i;

  // Response path: the ID tag bit selects the requester.
  assign b_tag      = m_bid_i[TB];
  assign s_bvalid_o = m_bvalid_i ? (b_tag ? 2'b10 : 2'b01) : 2'b00;
  assign m_bready_o = s_bready_i[b_tag];
  assign s_bid_o    = {1'b0, m_bid_i[TB-1:0]};
  assign b_hs       = m_bvalid_i & m_bready_o;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < 2; r++) begin
      inc[r] = aw_hs & (grant_q == r[0]);
      dec[r] = b_hs & (b_tag == r[0]);
    end
  end

  // AW and W may complete in either order or together; the pair ends when both are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_elig) begin
            grant_q <= pick;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            aw_done_q <= aw_done_q | aw_hs;
            w_done_q  <= w_done_q | w_hs;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Simultaneous increment and decrement cancel; decrement never wraps below 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q[0] <= '0;
      outst_q[1] <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (inc[r] & ~dec[r]) begin
          outst_q[r] <= outst_q[r] + 1'b1;
        end else if (dec[r] & ~inc[r] & (outst_q[r] != '0)) begin
          outst_q[r] <= outst_q[r] - 1'b1;
        end
      end
    end
  end

  // Sticky: a B with nothing outstanding, or a requester using the reserved tag bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((b_hs & (outst_q[b_tag] == '0)) | (m_awvalid_o & sel_awid[TB])) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_evict_wr_arb.sv
module tb_evict_wr_arb;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int ID_W   = 16;

  localparam logic [ADDR_W-1:0] ADDR0 = 64'h1;
  localparam logic [ADDR_W-1:0] ADDR1 = 64'h2000;
  localparam logic [DATA_W-1:0] DATA0 = 512'd12;
  localparam logic [DATA_W-1:0] DATA1 = 512'h55;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [ID_W-1:0]     awid0 = 16'h0003;
  logic [ID_W-1:0]     awid1 = 16'h0005;
  logic [1:0]          s_awvalid_i = '0;
  logic [1:0]          s_wvalid_i = '0;
  logic [1:0]          s_bready_i = '0;
  logic                m_awready_i = 1'b0;
  logic                m_wready_i = 1'b0;
  logic [ID_W-1:0]     m_bid_i = '0;
  logic                m_bvalid_i = 1'b0;
  logic [1:0]          s_awready_o, s_wready_o, s_bvalid_o;
  logic [ID_W-1:0]     s_bid_o, m_awid_o, m_wid_o;
  logic [ADDR_W-1:0]   m_awaddr_o;
  logic [DATA_W-1:0]   m_wdata_o;
  logic                m_awvalid_o, m_wvalid_o, m_bready_o, err_o;

  always #5 clk = ~clk;

  evict_wr_arb dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid_i({awid1, awid0}), .s_awaddr_i({ADDR1, ADDR0}),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i({DATA1, DATA0}), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bid_o(s_bid_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o),
    .m_awready_i(m_awready_i), .m_wid_o(m_wid_o), .m_wdata_o(m_wdata_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_bid_i(m_bid_i),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .err_o(err_o)
  );

  int passes = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_awvalid_i = '0; s_wvalid_i = '0; s_bready_i = '0;
    m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bid_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs settle 1 ns later.
  task automatic step(input logic [1:0] awv, input logic [1:0] wv, input logic mawr,
                      input logic mwr, input logic bv, input logic [15:0] bid,
                      input logic [1:0] brdy);
    @(negedge clk);
    s_awvalid_i = awv; s_wvalid_i = wv; m_awready_i = mawr; m_wready_i = mwr;
    m_bvalid_i = bv; m_bid_i = bid; s_bready_i = brdy;
    #1;
  endtask

  typedef struct packed {
    logic        rst;
    logic [1:0]  awv, wv;
    logic        mawr, mwr, bv;
    logic [15:0] bid;
    logic [1:0]  brdy;
    logic        e_mawv, e_mwv;
    logic [1:0]  e_awrdy, e_wrdy;
    logic [15:0] e_awid;
    logic [1:0]  e_bv;
    logic        e_brdy, e_err;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] awv, input logic [1:0] wv,
                              input logic mawr, input logic mwr, input logic bv,
                              input logic [15:0] bid, input logic [1:0] brdy,
                              input logic e_mawv, input logic e_mwv,
                              input logic [1:0] e_awrdy, input logic [1:0] e_wrdy,
                              input logic [15:0] e_awid, input logic [1:0] e_bv,
                              input logic e_brdy, input logic e_err);
    vec_t v;
    v = '{rst, awv, wv, mawr, mwr, bv, bid, brdy, e_mawv, e_mwv, e_awrdy, e_wrdy,
          e_awid, e_bv, e_brdy, e_err};
    return v;
  endfunction

  vec_t tbl[$];
  int   hs;

  initial begin
    // Reset state, observed while rst_n is low.
    do_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst m_awvalid", m_awvalid_o, 0);
    chk("rst m_wvalid", m_wvalid_o, 0);
    chk("rst s_awready", s_awready_o, 0);
    chk("rst s_wready", s_wready_o, 0);
    chk("rst s_bvalid", s_bvalid_o, 0);
    chk("rst err", err_o, 0);
    chk("rst m_awaddr", m_awaddr_o, 0);
    rst_n = 1'b1;

    // Req0 single write, then B routing.
    tbl.push_back(mk(1, 2'b01, 2'b01, 1, 1, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 16'h0000, 2'b00, 1, 1, 2'b01, 2'b01, 16'h0003, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1, 1, 1, 16'h0003, 2'b10, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b01, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1, 1, 1, 16'h0003, 2'b01, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b01, 1, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1, 1, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 0, 0));
    // Both requesters eligible: 0,1,0,1 with one idle cycle between grants.
    tbl.push_back(mk(1, 2'b11, 2'b11, 1, 1, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 0, 16'h0000, 2'b00, 1, 1, 2'b01, 2'b01, 16'h0003, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 0, 16'h0000, 2'b00, 1, 1, 2'b10, 2'b10, 16'h8005, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 0, 16'h0000, 2'b00, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 0, 16'h0000, 2'b00, 1, 1, 2'b01, 2'b01, 16'h0003, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 1, 16'h8005, 2'b10, 0, 0, 2'b00, 2'b00, 16'h0000, 2'b10, 1, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 1, 1, 0, 16'h0000, 2'b00, 1, 1, 2'b10, 2'b10, 16'h8005, 2'b00, 0, 0));

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      if (v.rst) do_reset();
      step(v.awv, v.wv, v.mawr, v.mwr, v.bv, v.bid, v.brdy);
      chk($sformatf("v%0d m_awvalid", i), m_awvalid_o, v.e_mawv);
      chk($sformatf("v%0d m_wvalid", i), m_wvalid_o, v.e_mwv);
      chk($sformatf("v%0d s_awready", i), s_awready_o, v.e_awrdy);
      chk($sformatf("v%0d s_wready", i), s_wready_o, v.e_wrdy);
      chk($sformatf("v%0d s_bvalid", i), s_bvalid_o, v.e_bv);
      chk($sformatf("v%0d m_bready", i), m_bready_o, v.e_brdy);
      chk($sformatf("v%0d s_bid", i), s_bid_o, v.bid & 16'h7fff);
      chk($sformatf("v%0d err", i), err_o, v.e_err);
      if (v.e_mawv) begin
        chk($sformatf("v%0d m_awid", i), m_awid_o, v.e_awid);
        chk($sformatf("v%0d m_wid", i), m_wid_o, v.e_awid);
        chk($sformatf("v%0d m_awaddr", i), m_awaddr_o, v.e_awid[15] ? ADDR1 : ADDR0);
        chk($sformatf("v%0d m_wdata", i), m_wdata_o, v.e_awid[15] ? DATA1 : DATA0);
      end
    end

    // W stalled three cycles after AW is taken.
    do_reset();
    step(2'b01, 2'b01, 1, 0, 0, 0, 0); chk("t3 idle", m_awvalid_o, 0);
    step(2'b01, 2'b01, 1, 0, 0, 0, 0); chk("t3 aw valid", m_awvalid_o, 1);
    chk("t3 w ready held", s_wready_o, 2'b00);
    step(2'b01, 2'b01, 1, 0, 0, 0, 0); chk("t3 aw dropped", m_awvalid_o, 0);
    chk("t3 w valid c2", m_wvalid_o, 1); chk("t3 w data c2", m_wdata_o, DATA0);
    chk("t3 aw ready after hs", s_awready_o, 2'b00);
    step(2'b01, 2'b01, 1, 0, 0, 0, 0); chk("t3 w valid c3", m_wvalid_o, 1);
    chk("t3 w data c3", m_wdata_o, DATA0);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t3 w ready", s_wready_o, 2'b01);
    chk("t3 aw still low", m_awvalid_o, 0);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t3 back idle", m_wvalid_o, 0);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t3 next grant", m_awvalid_o, 1);

    // Outstanding limit on req0, then same-cycle increment/decrement.
    do_reset();
    hs = 0;
    for (int k = 0; k < 16; k++) begin
      step(2'b01, 2'b01, 1, 1, 0, 0, 0);
      if (m_awvalid_o && m_awready_i) hs++;
    end
    chk("t4 eight writes", hs, 8);
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 2'b01, 1, 1, 0, 0, 0);
      chk($sformatf("t4 req0 blocked %0d", k), m_awvalid_o, 0);
    end
    step(2'b11, 2'b11, 1, 1, 0, 0, 0); chk("t4 idle before req1", m_awvalid_o, 0);
    step(2'b11, 2'b11, 1, 1, 0, 0, 0); chk("t4 req1 granted", m_awvalid_o, 1);
    chk("t4 req1 id", m_awid_o, 16'h8005);
    step(2'b01, 2'b01, 1, 1, 1, 16'h0003, 2'b01); chk("t4 b to req0", s_bvalid_o, 2'b01);
    chk("t4 still blocked", m_awvalid_o, 0);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t4 idle after b", m_awvalid_o, 0);
    step(2'b01, 2'b01, 1, 1, 1, 16'h0003, 2'b01); chk("t5 req0 regranted", m_awvalid_o, 1);
    chk("t5 req0 id", m_awid_o, 16'h0003);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t5 idle", m_awvalid_o, 0);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t5 one slot left", m_awvalid_o, 1);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t5 idle 2", m_awvalid_o, 0);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t5 full again", m_awvalid_o, 0);
    chk("t5 no err", err_o, 0);

    // Spurious B sets sticky error.
    do_reset();
    step(2'b00, 2'b00, 1, 1, 1, 16'h8005, 2'b10); chk("t6 b routed", s_bvalid_o, 2'b10);
    chk("t6 err not yet", err_o, 0);
    step(2'b00, 2'b00, 1, 1, 0, 0, 0); chk("t6 err set", err_o, 1);
    step(2'b00, 2'b00, 1, 1, 0, 0, 0); chk("t6 err sticky", err_o, 1);

    // Reserved ID bit from requester, then reset during a transfer.
    do_reset();
    awid0 = 16'h8003;
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t6 id err idle", err_o, 0);
    step(2'b01, 2'b01, 1, 1, 0, 0, 0); chk("t6 id tag replaced", m_awid_o, 16'h0003);
    step(2'b00, 2'b00, 1, 1, 0, 0, 0); chk("t6 id err set", err_o, 1);
    awid0 = 16'h0003;
    step(2'b01, 2'b01, 0, 0, 0, 0, 0);
    step(2'b01, 2'b01, 0, 0, 0, 0, 0); chk("t6 in xfer", m_awvalid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 rst awvalid", m_awvalid_o, 0);
    chk("t6 rst wvalid", m_wvalid_o, 0);
    chk("t6 rst awready", s_awready_o, 2'b00);
    chk("t6 rst wready", s_wready_o, 2'b00);
    chk("t6 rst err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/evict_wr_arb.md
Name: evict_wr_arb

Overview:
- Two-requester arbiter that shares one AXI write port (AW/W/B, single-beat 512-bit writes) between the eviction writeback path (req 0) and a second write source such as a flush/fill writer (req 1).
- Sits between the eviction AW/W issuer and the memory-side AXI interconnect.
- Grants round-robin and keeps each AW+W pair atomic.
- Limits outstanding writes per requester and routes B responses back using the ID MSB.

Parameters:
ADDR_W, 64, address width
DATA_W, 512, write data width (one beat)
ID_W, 16, AXI ID width; bit ID_W-1 is reserved for requester tagging
MAX_OUTST, 8, max outstanding writes (AW accepted, B not yet returned) per requester

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_awid_i  in  2*ID_W  per-requester AW ID; slice r = [r*ID_W +: ID_W]; MSB must be 0
s_awaddr_i  in  2*ADDR_W  per-requester AW address
s_awvalid_i  in  2  per-requester AW valid
s_awready_o  out  2  per-requester AW ready
s_wdata_i  in  2*DATA_W  per-requester W data
s_wvalid_i  in  2  per-requester W valid
s_wready_o  out  2  per-requester W ready
s_bid_o  out  ID_W  B ID returned to requester, MSB cleared
s_bvalid_o  out  2  per-requester B valid
s_bready_i  in  2  per-requester B ready
m_awid_o  out  ID_W  {grant, s_awid[ID_W-2:0]}
m_awaddr_o  out  ADDR_W  downstream AW address
m_awvalid_o  out  1  downstream AW valid
m_awready_i  in  1  downstream AW ready
m_wid_o  out  ID_W  same as m_awid_o
m_wdata_o  out  DATA_W  downstream W data
m_wvalid_o  out  1  downstream W valid
m_wready_i  in  1  downstream W ready
m_bid_i  in  ID_W  downstream B ID
m_bvalid_i  in  1  downstream B valid
m_bready_o  out  1  downstream B ready
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0):
  - state=S_IDLE, grant=0, rr_last=1 (so req 0 wins first), aw_done=w_done=0, outst[0..1]=0, err_o=0.
  - All valid/ready outputs are 0; data/ID outputs are don't-care but driven 0.
- Reset mid-transfer drops the transfer and the counters; no recovery is attempted.
- Eligibility: req r is eligible when s_awvalid_i[r] & s_wvalid_i[r] & (outst[r] < MAX_OUTST). Both AW and W valid are required before a grant.
- State S_IDLE:
  - If any requester is eligible, register grant (round-robin: when both are eligible, pick ~rr_last), set rr_last=grant, go to S_XFER.
  - Latency: eligible in cycle N gives m_awvalid_o/m_wvalid_o high in cycle N+1.
- State S_XFER:
  - m_awvalid_o = s_awvalid_i[grant] & ~aw_done; s_awready_o[grant] = m_awready_i & ~aw_done.
  - m_wvalid_o = s_wvalid_i[grant] & ~w_done; s_wready_o[grant] = m_wready_i & ~w_done.
  - The non-granted requester's ready outputs are 0.
  - aw_done/w_done set on their handshakes. When both are done (including the same-cycle case), clear the flags and return to S_IDLE.
  - There is one idle cycle between grants, so a back-to-back single requester sustains 1 write per 2 cycles minimum.
- Outstanding counters:
  - outst[grant]++ on m_awvalid_o & m_awready_i.
  - outst[r]-- on m_bvalid_i & m_bready_o with m_bid_i[ID_W-1]==r.
  - Increment and decrement on the same counter in the same cycle leave it unchanged.
  - The counter saturates at 0; a B for a counter at 0 sets err_o.
- B routing (combinational):
  - b = m_bid_i[ID_W-1]; s_bvalid_o[b] = m_bvalid_i; m_bready_o = s_bready_i[b].
  - s_bid_o = m_bid_i with MSB cleared.
- err_o also sets if a granted requester presents s_awid MSB=1. err_o clears only on reset.
- The arbiter does not reorder, buffer or modify data; W is always single-beat (no wlast).

Decomposition:
- Shared package: ADDR_W/DATA_W/ID_W defaults, TID_W=10, the state enum {S_IDLE, S_XFER}, and a helper for the requester-tag bit position.
- Sub-module rr_arb2 (2-way round-robin picker with rr_last register) is natural and reusable.
- Outstanding counters and B routing stay inline.

Test Plan:
1. Req0 only, awaddr=0x1, wdata=12, awid=0x3, ready=1 -> m_awaddr_o=0x1, m_awid_o=0x0003, m_wdata_o=12 in cycle after request; B bid=0x0003 -> s_bvalid_o=2'b01, s_bid_o=0x0003, outst0 back to 0.
2. Both requesters continuously eligible -> grants alternate 0,1,0,1; req1 writes carry m_awid_o MSB=1; B with bid=0x8005 -> s_bvalid_o=2'b10, s_bid_o=0x0005.
3. m_wready_i held 0 for 3 cycles while AW accepted -> m_awvalid_o drops after the AW handshake, W is held stable, and state returns to S_IDLE only after the W handshake.
4. Req0 issues 8 writes with no B -> req0 ineligible on the 9th; req1 is still granted; one B for req0 -> req0 granted next.
5. Same-cycle AW handshake for req0 and B for req0 -> outst0 unchanged.
6. B with bid MSB=1 while outst1=0 -> err_o=1 and stays 1; assert rst_n=0 mid-S_XFER -> all valids 0 immediately and err_o=0.
